// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the i/d memory port arbiter.
package mem_arb_pkg;

    // 38-bit access word as presented by the core: {rsvd, size, byte addr, rNw}.
    typedef struct packed {
        logic [2:0]  rsvd;
        logic [1:0]  size;
        logic [31:0] addr;
        logic        rnw;
    } access_t;

    localparam int ACC_W = $bits(access_t);

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_BAD = 2'd3;

    localparam logic [31:0] DEF_FILL    = 32'hAAAA_AAAA;
    localparam logic [31:0] ABORT_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_ACK
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side req/ack ports, SRAM macro port and tube outputs of the arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic             i_req, i_ack, i_priv, i_abort;
    logic [ACC_W-1:0] i_access;
    logic [31:0]      i_rdata;

    logic             d_req, d_ack, d_priv, d_abort;
    logic [ACC_W-1:0] d_access;
    logic [31:0]      d_rdata, d_wdata;

    logic             sram_en, sram_we;
    logic [3:0]       sram_be;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]      sram_wdata, sram_rdata;

    logic             tube_valid, sim_exit;
    logic [7:0]       tube_data;

    modport slave (
        input  i_req, i_access, i_priv, d_req, d_access, d_priv, d_wdata, sram_rdata,
        output i_ack, i_rdata, i_abort, d_ack, d_rdata, d_abort,
               sram_en, sram_we, sram_be, sram_addr, sram_wdata,
               tube_valid, tube_data, sim_exit
    );

    modport master (
        output i_req, i_access, i_priv, d_req, d_access, d_priv, d_wdata, sram_rdata,
        input  i_ack, i_rdata, i_abort, d_ack, d_rdata, d_abort,
               sram_en, sram_we, sram_be, sram_addr, sram_wdata,
               tube_valid, tube_data, sim_exit
    );
endinterface

// File: rtl/mem_lane_ctrl.sv
// Size + low address bits -> SRAM byte enables and the matching 32-bit read-lane mask.
module mem_lane_ctrl
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    output logic [3:0]  o_be,
    output logic [31:0] o_lane_mask
);

    // Byte enables per size; illegal size selects nothing (that access is aborted anyway).
    always_comb begin
        o_be = 4'b0000;
        case (i_size)
            SZ_W:    o_be = 4'b1111;
            SZ_H:    o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_B:    o_be = 4'b0001 << i_addr_lo;
            default: o_be = 4'b0000;
        endcase
    end

    // Expand each byte enable across its 8 data bits.
    always_comb begin
        o_lane_mask = '0;
        for (int k = 0; k < 4; k++) begin
            o_lane_mask[8*k +: 8] = {8{o_be[k]}};
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the i-side and d-side 4-phase req/ack ports,
// with round-robin on contention, access decode/abort and tube write diversion.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] TUBE_ADDR = 32'h0000_C000,
    parameter logic [7:0]  EXIT_CHAR = 8'h04,
    parameter logic [31:0] FILL      = DEF_FILL
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    state_e      r_state, w_next;
    access_t     r_acc, w_sel;
    logic [31:0] r_wdata, r_rdata;
    logic        r_gnt_d, r_last_d, r_abort, r_tube, r_resp_abort;
    logic        w_any, w_gnt_d, w_oor, w_tube, w_abort, w_bypass, w_gnt_req;
    logic        w_en, w_ack, w_tube_hit, w_unused_ok;
    logic [3:0]  w_be;
    logic [31:0] w_mask;

    // Grant: a lone requester wins; on contention the side not granted last time wins.
    assign w_any   = bus.i_req | bus.d_req;
    assign w_gnt_d = bus.d_req & (~bus.i_req | ~r_last_d);
    assign w_sel   = w_gnt_d ? access_t'(bus.d_access) : access_t'(bus.i_access);

    // Decode of the winning access; a tube write is checked before range so it never aborts.
    assign w_oor   = |w_sel.addr[31:ADDR_W+2];
    assign w_tube  = w_gnt_d & ~w_sel.rnw & (w_sel.addr == TUBE_ADDR);
    assign w_abort = ~w_tube & ((~w_gnt_d & ~w_sel.rnw) | w_oor | (w_sel.size == SZ_BAD));

    assign w_bypass  = r_abort | r_tube;
    assign w_gnt_req = r_gnt_d ? bus.d_req : bus.i_req;

    mem_lane_ctrl u_lane (
        .i_size      (r_acc.size),
        .i_addr_lo   (r_acc.addr[1:0]),
        .o_be        (w_be),
        .o_lane_mask (w_mask)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state. Bypassed accesses (abort/tube) still spend the ISSUE cycle, with the
    // SRAM cycle suppressed, so their ack lands one edge earlier than a real access.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_any) w_next = ST_ISSUE;
            ST_ISSUE:   w_next = w_bypass ? ST_ACK : ST_CAPTURE;
            ST_CAPTURE: w_next = ST_ACK;
            ST_ACK:     if (!w_gnt_req) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Grant bookkeeping, access capture and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_d      <= 1'b0;
            r_last_d     <= 1'b0;
            r_acc        <= '0;
            r_wdata      <= '0;
            r_abort      <= 1'b0;
            r_tube       <= 1'b0;
            r_rdata      <= '0;
            r_resp_abort <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any) begin
                    r_gnt_d <= w_gnt_d;
                    if (bus.i_req && bus.d_req) r_last_d <= w_gnt_d;
                    r_acc   <= w_sel;
                    r_wdata <= bus.d_wdata;
                    r_abort <= w_abort;
                    r_tube  <= w_tube;
                end
                ST_ISSUE: if (w_bypass) begin
                    r_rdata      <= r_abort ? ABORT_RDATA : '0;
                    r_resp_abort <= r_abort;
                end
                ST_CAPTURE: begin
                    r_rdata      <= (bus.sram_rdata & w_mask) | (FILL & ~w_mask);
                    r_resp_abort <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign w_en       = (r_state == ST_ISSUE) & ~w_bypass;
    assign w_ack      = (r_state == ST_ACK);
    assign w_tube_hit = (r_state == ST_ISSUE) & r_tube;

    assign bus.sram_en    = w_en;
    assign bus.sram_we    = w_en & ~r_acc.rnw;
    assign bus.sram_be    = w_en ? w_be : 4'b0000;
    assign bus.sram_addr  = r_acc.addr[ADDR_W+1:2];
    assign bus.sram_wdata = r_wdata;

    assign bus.i_ack   = w_ack & ~r_gnt_d;
    assign bus.d_ack   = w_ack & r_gnt_d;
    assign bus.i_rdata = r_gnt_d ? 32'h0 : r_rdata;
    assign bus.d_rdata = r_gnt_d ? r_rdata : 32'h0;
    assign bus.i_abort = ~r_gnt_d & r_resp_abort;
    assign bus.d_abort = r_gnt_d & r_resp_abort;

    assign bus.tube_valid = w_tube_hit & (r_wdata[7:0] != EXIT_CHAR);
    assign bus.sim_exit   = w_tube_hit & (r_wdata[7:0] == EXIT_CHAR);
    assign bus.tube_data  = r_wdata[7:0];

    // Privilege is carried for tube/debug consumers only; reserved and upper address bits
    // are decoded before registering and not needed afterwards.
    assign w_unused_ok = ^{bus.i_priv, bus.d_priv, r_acc.rsvd, r_acc.addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus round-robin and reset sequences.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16)) bus();

    mem_port_arbiter #(
        .ADDR_W(16), .TUBE_ADDR(32'h0000_C000), .EXIT_CHAR(8'h04), .FILL(32'hAAAA_AAAA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // SRAM macro model: registered read, byte-lane write, one cycle after sram_en.
    logic [31:0] mem [0:1023];
    bit mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'h0;
            mem_clr <= 1'b0;
        end else if (bus.sram_en) begin
            bus.sram_rdata <= mem[bus.sram_addr[9:0]];
            if (bus.sram_we)
                for (int k = 0; k < 4; k++)
                    if (bus.sram_be[k]) mem[bus.sram_addr[9:0]][8*k +: 8] <= bus.sram_wdata[8*k +: 8];
        end
    end

    // Event counters sampled mid-cycle.
    int en_cnt = 0, tv_cnt = 0, ex_cnt = 0;
    logic [3:0] last_be = '0;
    logic [7:0] last_td = '0;
    always @(negedge clk) begin
        if (bus.sram_en)    begin en_cnt++; last_be = bus.sram_be; end
        if (bus.tube_valid) begin tv_cnt++; last_td = bus.tube_data; end
        if (bus.sim_exit)   ex_cnt++;
    end

    // Protocol watch: req must not drop before ack; the two acks are never both high.
    logic q_i_req = 1'b0, q_d_req = 1'b0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (q_i_req && !bus.i_req && !bus.i_ack) begin fails++; $display("FAIL proto_i: req dropped before ack"); end
            if (q_d_req && !bus.d_req && !bus.d_ack) begin fails++; $display("FAIL proto_d: req dropped before ack"); end
            if (bus.i_ack && bus.d_ack) begin fails++; $display("FAIL both_ack: i_ack and d_ack both high"); end
        end
        q_i_req = bus.i_req;
        q_d_req = bus.d_req;
    end

    function automatic logic [37:0] acc(input logic [1:0] sz, input logic [31:0] a, input bit rnw);
        return {3'b000, sz, a, rnw};
    endfunction

    task automatic set_req(input bit side_d, input logic [37:0] a, input logic [31:0] wd);
        bus.d_wdata = wd;
        if (side_d) begin bus.d_access = a; bus.d_req = 1'b1; end
        else        begin bus.i_access = a; bus.i_req = 1'b1; end
    endtask

    task automatic wait_ack(input bit side_d, output int k);
        k = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (side_d ? bus.d_ack : bus.i_ack) begin k = n; break; end
        end
    endtask

    task automatic release_req(input bit side_d, input string name);
        @(negedge clk);
        if (side_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (!(side_d ? bus.d_ack : bus.i_ack)) break;
        end
        chk({name, "_ackdrop"}, 32'(side_d ? bus.d_ack : bus.i_ack), 32'h0);
    endtask

    // Two simultaneous requests: i reads 0x100, d reads 0x104.
    task automatic rr_round(input bit exp_first_d, input string nm);
        int k;
        bit first_d;
        @(negedge clk);
        bus.i_access = acc(SZ_W, 32'h100, 1'b1);
        bus.d_access = acc(SZ_W, 32'h104, 1'b1);
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        k = 0;
        first_d = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus.i_ack || bus.d_ack) begin k = n; first_d = bus.d_ack; break; end
        end
        chk({nm, "_first_edge"}, 32'(k), 32'd3);
        chk({nm, "_first_is_d"}, 32'(first_d), 32'(exp_first_d));
        chk({nm, "_first_rdata"}, first_d ? bus.d_rdata : bus.i_rdata,
            first_d ? 32'hCAFE_0000 : 32'h55AD_BEEF);
        release_req(first_d, {nm, "_first"});
        wait_ack(!first_d, k);
        chk({nm, "_second_edge"}, 32'(k), 32'd3);
        chk({nm, "_second_rdata"}, first_d ? bus.i_rdata : bus.d_rdata,
            first_d ? 32'h55AD_BEEF : 32'hCAFE_0000);
        release_req(!first_d, {nm, "_second"});
    endtask

    typedef struct {
        bit          d;
        logic [1:0]  sz;
        logic [31:0] addr;
        bit          rnw;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] rd;
        bit          ab;
        int          edg;
        logic [3:0]  be;     // 0: no SRAM cycle expected
        int          tube;   // 0 none, 1 tube_valid, 2 sim_exit
    } vec_t;

    vec_t tbl [14];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, en0, tv0, ex0;
        vec_t t;
        string nm;

        bus.i_req = 0; bus.d_req = 0; bus.i_priv = 0; bus.d_priv = 0;
        bus.i_access = '0; bus.d_access = '0; bus.d_wdata = '0;

        //          d  sz    addr          rnw wdata          chk rdata          ab edg be       tube
        tbl[0]  = '{1, SZ_W, 32'h0000_0100, 0, 32'hDEAD_BEEF, 0, 32'h0,          0, 3, 4'b1111, 0};
        tbl[1]  = '{1, SZ_W, 32'h0000_0100, 1, 32'h0,         1, 32'hDEAD_BEEF,  0, 3, 4'b1111, 0};
        tbl[2]  = '{1, SZ_B, 32'h0000_0103, 0, 32'h5500_0000, 0, 32'h0,          0, 3, 4'b1000, 0};
        tbl[3]  = '{0, SZ_H, 32'h0000_0102, 1, 32'h0,         1, 32'h55AD_AAAA,  0, 3, 4'b1100, 0};
        tbl[4]  = '{0, SZ_B, 32'h0000_0101, 1, 32'h0,         1, 32'hAAAA_BEAA,  0, 3, 4'b0010, 0};
        tbl[5]  = '{1, SZ_W, 32'h0004_0000, 1, 32'h0,         1, 32'hFFFF_FFFF,  1, 2, 4'b0000, 0};
        tbl[6]  = '{0, SZ_W, 32'h0000_0200, 0, 32'h1234_5678, 1, 32'hFFFF_FFFF,  1, 2, 4'b0000, 0};
        tbl[7]  = '{0, SZ_W, 32'h0000_0200, 1, 32'h0,         1, 32'h0000_0000,  0, 3, 4'b1111, 0};
        tbl[8]  = '{1, SZ_BAD, 32'h0000_0100, 1, 32'h0,       1, 32'hFFFF_FFFF,  1, 2, 4'b0000, 0};
        tbl[9]  = '{1, SZ_H, 32'h0000_0106, 0, 32'hCAFE_0000, 0, 32'h0,          0, 3, 4'b1100, 0};
        tbl[10] = '{1, SZ_W, 32'h0000_0104, 1, 32'h0,         1, 32'hCAFE_0000,  0, 3, 4'b1111, 0};
        tbl[11] = '{1, SZ_B, 32'h0000_0107, 1, 32'h0,         1, 32'hCAAA_AAAA,  0, 3, 4'b1000, 0};
        tbl[12] = '{1, SZ_W, 32'h0000_C000, 0, 32'h0000_0041, 0, 32'h0,          0, 2, 4'b0000, 1};
        tbl[13] = '{1, SZ_W, 32'h0000_C000, 0, 32'h0000_0004, 0, 32'h0,          0, 2, 4'b0000, 2};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_acks",   32'({bus.i_ack, bus.d_ack, bus.i_abort, bus.d_abort}), 32'h0);
        chk("rst_sram",   32'({bus.sram_en, bus.sram_we, bus.sram_be}), 32'h0);
        chk("rst_addr",   32'(bus.sram_addr), 32'h0);
        chk("rst_rdata",  bus.i_rdata | bus.d_rdata, 32'h0);
        chk("rst_tube",   32'({bus.tube_valid, bus.sim_exit, bus.tube_data}), 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            t  = tbl[v];
            nm = $sformatf("v%0d", v);
            @(negedge clk);
            en0 = en_cnt; tv0 = tv_cnt; ex0 = ex_cnt;
            set_req(t.d, acc(t.sz, t.addr, t.rnw), t.wd);
            wait_ack(t.d, k);
            chk({nm, "_edge"}, 32'(k), 32'(t.edg));
            chk({nm, "_other_ack"}, 32'(t.d ? bus.i_ack : bus.d_ack), 32'h0);
            chk({nm, "_abort"}, 32'(t.d ? bus.d_abort : bus.i_abort), 32'(t.ab));
            if (t.chk_rd) chk({nm, "_rdata"}, t.d ? bus.d_rdata : bus.i_rdata, t.rd);
            release_req(t.d, nm);
            chk({nm, "_sram_cycles"}, 32'(en_cnt - en0), 32'(t.be != 4'b0000));
            if (t.be != 4'b0000) chk({nm, "_be"}, 32'(last_be), 32'(t.be));
            chk({nm, "_tube_valid"}, 32'(tv_cnt - tv0), 32'(t.tube == 1));
            chk({nm, "_sim_exit"},   32'(ex_cnt - ex0), 32'(t.tube == 2));
            if (t.tube == 1) chk({nm, "_tube_data"}, 32'(last_td), 32'(t.wd[7:0]));
        end

        // Contention: first round goes to d (last grant reset to i), second to i.
        rr_round(1'b1, "rr1");
        rr_round(1'b0, "rr2");

        // Reset while the SRAM cycle is being issued; held req is served afresh.
        @(negedge clk);
        bus.d_access = acc(SZ_W, 32'h100, 1'b1);
        bus.d_req = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_en_before", 32'(bus.sram_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_en",   32'(bus.sram_en), 32'h0);
        chk("rstmid_acks", 32'({bus.i_ack, bus.d_ack}), 32'h0);
        chk("rstmid_be",   32'(bus.sram_be), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(1'b1, k);
        chk("rstmid_reissue_edge", 32'(k), 32'd3);
        chk("rstmid_reissue_rdata", bus.d_rdata, 32'h55AD_BEEF);
        release_req(1'b1, "rstmid");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
